// File: rtl/std_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready depends only on state and rst,
// so no combinational path exists from out_ready back to in_ready.
module std_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             main_from_skid;
    logic             skid_en;

    assign in_ready  = (state != FULL) && !rst;
    assign out_valid = (state != EMPTY);
    assign count     = state;
    assign out_data  = main_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Load enables for the payload flops; nothing is written during rst or flush.
    always_comb begin
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (!rst && !flush) begin
            case (state)
                EMPTY: main_en = in_fire;
                BUSY: begin
                    main_en = in_fire && out_fire;
                    skid_en = in_fire && !out_fire;
                end
                FULL: begin
                    main_en        = out_fire;
                    main_from_skid = out_fire;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) state <= BUSY;
                BUSY: begin
                    if (in_fire && !out_fire)      state <= FULL;
                    else if (!in_fire && out_fire) state <= EMPTY;
                end
                FULL: if (out_fire) state <= BUSY;
                default: state <= EMPTY;
            endcase
        end
    end

    // Payload storage: enable-only, no reset.
    always_ff @(posedge clk) begin
        if (main_en) main_q <= main_from_skid ? skid_q : in_data;
        if (skid_en) skid_q <= in_data;
    end

endmodule

// File: tb/tb_std_skid_buf.sv
// Scoreboard bench for std_skid_buf: directed scenarios followed by random traffic,
// checked against a queue-based FIFO reference model.
module tb_std_skid_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] count;

    std_skid_buf #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic       m_in_ready = 1'b0;
    logic       mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a FIFO of at most two beats, cleared by rst or flush.
    always @(posedge clk) begin
        if (rst || flush) exp_q.delete();
        else if (in_valid && m_in_ready) exp_q.push_back(in_data);
    end

    // Monitor: compares status every cycle and pops the scoreboard on each out_fire.
    always @(negedge clk) begin
        if (mon_en) begin
            m_in_ready = (exp_q.size() < 2) && !rst;
            chk("count", int'(count), exp_q.size());
            chk("count_range", int'(count == 2'd3), 0);
            chk("in_ready", int'(in_ready), int'(m_in_ready));
            chk("out_valid", int'(out_valid), int'(exp_q.size() > 0));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                chk("out_data", int'(out_data), int'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [7:0] d, input logic ordy);
        @(posedge clk);
        #1;
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    initial begin
        logic       hold;
        logic       r;
        logic       f;
        logic       iv;
        logic [7:0] d;

        // Reset held three cycles with a beat offered
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(posedge clk);
        #1 mon_en = 1'b1;
        drive(1, 0, 1, 8'h99, 0);
        drive(1, 0, 1, 8'h99, 0);
        drive(0, 0, 0, 8'h00, 0);

        // Streaming
        drive(0, 0, 1, 8'h11, 1);
        drive(0, 0, 1, 8'h22, 1);
        drive(0, 0, 1, 8'h33, 1);
        drive(0, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);

        // Back-pressure, then full hold with 0xFF offered
        drive(0, 0, 1, 8'hA5, 0);
        drive(0, 0, 1, 8'h5A, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'hFF, 0);
        drive(0, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);

        // Flush while full with a beat offered
        drive(0, 0, 1, 8'hA5, 0);
        drive(0, 0, 1, 8'h5A, 0);
        drive(0, 1, 1, 8'h77, 0);
        drive(0, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);

        // Simultaneous in_fire and out_fire while busy
        drive(0, 0, 1, 8'h01, 0);
        drive(0, 0, 1, 8'h02, 1);
        drive(0, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);

        // Random traffic; a stalled beat is held stable until accepted
        for (int i = 0; i < 3000; i++) begin
            hold = in_valid && !in_ready;
            r    = ($urandom_range(99) == 0);
            f    = ($urandom_range(99) < 3);
            iv   = hold ? 1'b1 : ($urandom_range(99) < 70);
            d    = hold ? in_data : 8'($urandom);
            drive(r, f, iv, d, ($urandom_range(99) < 60));
        end
        drive(0, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
